deserializer_out: RTL and testbench

Receive-side counterpart of the serial transmit path. Takes the bit-serial stream of 9-bit symbols {k, byte[7:0]} and finds symbol alignment by hunting for the comma symbol {1, 8'h3C}. Once aligned, it reassembles each frame COMMA, B0, B1, B2 into a 32-bit word {8'h00, B2, B1, B0}. It sits directly downstream of the serializer and the serial link.

---
 rtl/deserializer_out.sv | 158 +++++++++++++++
 tb/tb_deserializer_out.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_out.sv
// Serial symbol receiver: hunts for the comma symbol to find 9-bit symbol
// alignment, confirms it over several consecutive commas, then reassembles
// COMMA, B0..B(N-1) frames into a zero-padded 32-bit word.
module deserializer_out #(
    parameter logic [7:0] COMMA       = 8'h3C,
    parameter int         NUM_BYTES   = 3,
    parameter int         LOCK_COMMAS = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_i,
    input  logic        bit_vld_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        lock_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_ALIGN,
        ST_LOCKED
    } state_t;

    localparam logic [8:0] COMMA_SYM = {1'b1, COMMA};
    localparam logic [3:0] LOCK_N    = 4'(LOCK_COMMAS);
    localparam logic [1:0] LAST_IDX  = 2'(NUM_BYTES - 1);

    state_t          state_q;
    logic [8:0]      shreg_q;
    logic [8:0]      shreg_d;
    logic [3:0]      bit_cnt_q;
    logic [3:0]      comma_cnt_q;
    logic [1:0]      byte_idx_q;
    logic [3:0][7:0] lanes_q;
    logic [3:0][7:0] lanes_new;
    logic [31:0]     word_d;
    logic [31:0]     data_q;
    logic            valid_q;
    logic            lock_q;
    logic            err_q;
    logic            is_comma;
    logic            sym_done;

    assign shreg_d  = {shreg_q[7:0], data_i};
    assign is_comma = (shreg_d == COMMA_SYM);
    assign sym_done = (bit_cnt_q == 4'd8);

    // Word that would be published if the current symbol is the last data byte.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        lanes_new             = lanes_q;
        lanes_new[byte_idx_q] = shreg_d[7:0];
        word_d                = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            word_d[8*i +: 8] = lanes_new[i];
        end
    end

    // Alignment FSM, symbol decode and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the byte lanes are a handful of flops, so they are reset along with the rest of the state.
            state_q     <= ST_HUNT;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            byte_idx_q  <= '0;
            lanes_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bit_vld_i) begin
                shreg_q <= shreg_d;
                case (state_q)
                    ST_HUNT: begin
                        if (is_comma) begin
                            bit_cnt_q   <= '0;
                            comma_cnt_q <= 4'd1;
                            byte_idx_q  <= '0;
                            if (LOCK_COMMAS == 1) begin
                                state_q <= ST_LOCKED;
                                lock_q  <= 1'b1;
                            end else begin
                                state_q <= ST_ALIGN;
                            end
                        end
                    end
                    ST_ALIGN: begin
                        if (sym_done) begin
                            bit_cnt_q <= '0;
                            if (is_comma) begin
                                comma_cnt_q <= comma_cnt_q + 4'd1;
                                if (comma_cnt_q + 4'd1 == LOCK_N) begin
                                    state_q    <= ST_LOCKED;
                                    lock_q     <= 1'b1;
                                    byte_idx_q <= '0;
                                end
                            end else begin
                                state_q     <= ST_HUNT;
                                comma_cnt_q <= '0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    ST_LOCKED: begin
                        if (sym_done) begin
                            bit_cnt_q <= '0;
                            if (!shreg_d[8]) begin
                                // Data symbol: collect, publish on the last lane.
                                lanes_q[byte_idx_q] <= shreg_d[7:0];
                                if (byte_idx_q == LAST_IDX) begin
                                    data_q     <= word_d;
                                    valid_q    <= 1'b1;
                                    byte_idx_q <= '0;
                                end else begin
                                    byte_idx_q <= byte_idx_q + 2'd1;
                                end
                            end else if (is_comma) begin
                                // Comma mid-frame truncates it and starts a new frame.
                                if (byte_idx_q != '0) begin
                                    err_q      <= 1'b1;
                                    byte_idx_q <= '0;
                                end
                            end else begin
                                // Unknown control symbol: alignment is no longer trusted.
                                err_q       <= 1'b1;
                                state_q     <= ST_HUNT;
                                lock_q      <= 1'b0;
                                comma_cnt_q <= '0;
                                byte_idx_q  <= '0;
                                shreg_q     <= '0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_HUNT;
                        lock_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign lock_o  = lock_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_deserializer_out.sv
// Bench for deserializer_out: directed scenarios with randomized content,
// every cycle compared against a symbol-level reference model.
module tb_deserializer_out;

    localparam int         NUM_BYTES   = 3;
    localparam int         LOCK_COMMAS = 2;
    localparam logic [8:0] K_COMMA     = {1'b1, 8'h3C};

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_i;
    logic        bit_vld_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        lock_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    deserializer_out #(
        .COMMA      (8'h3C),
        .NUM_BYTES  (NUM_BYTES),
        .LOCK_COMMAS(LOCK_COMMAS)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .bit_vld_i(bit_vld_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .lock_o   (lock_o),
        .err_o    (err_o)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n_valid = 0;
    int n_err = 0;

    // Reference model: a sliding window of the last 9 bits, a count of
    // bits since the alignment point, and the list of bytes of the frame.
    logic [8:0]  m_win;
    bit          m_aligned;
    bit          m_locked;
    int          m_commas;
    int          m_bits_since;
    logic [7:0]  m_bytes[$];
    logic [31:0] m_data;
    bit          m_valid;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win        = '0;
        m_aligned    = 0;
        m_locked     = 0;
        m_commas     = 0;
        m_bits_since = 0;
        m_bytes.delete();
        m_data       = '0;
        m_valid      = 0;
        m_err        = 0;
    endtask

    task automatic model_bit(input logic b);
        logic [8:0]  sym;
        logic [31:0] word;
        m_valid = 0;
        m_err   = 0;
        m_win   = {m_win[7:0], b};
        if (!m_aligned) begin
            if (m_win == K_COMMA) begin
                m_aligned    = 1;
                m_commas     = 1;
                m_bits_since = 0;
                m_locked     = (LOCK_COMMAS == 1);
            end
        end else begin
            m_bits_since++;
            if (m_bits_since % 9 == 0) begin
                sym = m_win;
                if (!m_locked) begin
                    if (sym == K_COMMA) begin
                        m_commas++;
                        if (m_commas >= LOCK_COMMAS) m_locked = 1;
                    end else begin
                        m_aligned = 0;
                        m_commas  = 0;
                    end
                end else if (sym[8] == 1'b0) begin
                    m_bytes.push_back(sym[7:0]);
                    if (m_bytes.size() == NUM_BYTES) begin
                        word = 0;
                        for (int i = 0; i < NUM_BYTES; i++) word = word + (32'(m_bytes[i]) << (8 * i));
                        m_data  = word;
                        m_valid = 1;
                        m_bytes.delete();
                    end
                end else if (sym == K_COMMA) begin
                    if (m_bytes.size() != 0) begin
                        m_err = 1;
                        m_bytes.delete();
                    end
                end else begin
                    m_err     = 1;
                    m_locked  = 0;
                    m_aligned = 0;
                    m_commas  = 0;
                    m_win     = '0;
                    m_bytes.delete();
                end
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".valid"}, 32'(valid_o), 32'(m_valid));
        check({where, ".err"}, 32'(err_o), 32'(m_err));
        check({where, ".lock"}, 32'(lock_o), 32'(m_locked));
        check({where, ".data"}, data_o, m_data);
        if (valid_o === 1'b1) n_valid++;
        if (err_o === 1'b1) n_err++;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_i);
        data_i    = b;
        bit_vld_i = 1'b1;
        model_bit(b);
        @(posedge clk_i);
        #1;
        compare_all("bit");
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        bit_vld_i = 1'b0;
        data_i    = 1'($urandom);
        m_valid   = 0;
        m_err     = 0;
        @(posedge clk_i);
        #1;
        compare_all("idle");
    endtask

    task automatic send_sym(input logic [8:0] s, input bit toggle);
        for (int i = 8; i >= 0; i--) begin
            send_bit(s[i]);
            if (toggle) idle_cycle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i     = 1'b1;
        bit_vld_i = 1'b0;
        data_i    = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        compare_all("reset");
    endtask

    task automatic scenario2(input bit toggle);
        send_sym(K_COMMA, toggle);
        send_sym({1'b0, 8'hC3}, toggle);
        send_sym({1'b0, 8'hB2}, toggle);
        send_sym({1'b0, 8'hA1}, toggle);
        send_sym(K_COMMA, toggle);
    endtask

    initial begin
        int v0;
        int e0;
        logic [7:0] rb;
        rst_i     = 1'b0;
        data_i    = 1'b0;
        bit_vld_i = 1'b0;
        model_reset();

        // 1: reset, then idle commas until lock.
        do_reset();
        check("reset.lock0", 32'(lock_o), 32'd0);
        v0 = n_valid;
        e0 = n_err;
        send_sym(K_COMMA, 0);
        check("s1.lock_after_1", 32'(lock_o), 32'd0);
        send_sym(K_COMMA, 0);
        check("s1.lock_after_2", 32'(lock_o), 32'd1);
        check("s1.no_valid", 32'(n_valid - v0), 32'd0);
        check("s1.no_err", 32'(n_err - e0), 32'd0);

        // 2: one frame back-to-back.
        v0 = n_valid;
        scenario2(0);
        check("s2.valid_count", 32'(n_valid - v0), 32'd1);
        check("s2.data", data_o, 32'h00A1B2C3);

        // 3: misaligned start after reset.
        do_reset();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        send_sym(K_COMMA, 0);
        send_sym(K_COMMA, 0);
        check("s3.lock", 32'(lock_o), 32'd1);
        send_sym({1'b0, 8'h11}, 0);
        send_sym({1'b0, 8'h22}, 0);
        send_sym({1'b0, 8'h33}, 0);
        check("s3.data", data_o, 32'h00332211);

        // 4: truncated frame then a full frame.
        v0 = n_valid;
        e0 = n_err;
        send_sym(K_COMMA, 0);
        send_sym({1'b0, 8'h55}, 0);
        send_sym(K_COMMA, 0);
        check("s4.err_count", 32'(n_err - e0), 32'd1);
        check("s4.no_valid", 32'(n_valid - v0), 32'd0);
        check("s4.lock", 32'(lock_o), 32'd1);
        send_sym({1'b0, 8'h01}, 0);
        send_sym({1'b0, 8'h02}, 0);
        send_sym({1'b0, 8'h03}, 0);
        check("s4.data", data_o, 32'h00030201);

        // 5: non-comma K symbol drops lock; relock needs two commas.
        e0 = n_err;
        send_sym({1'b1, 8'hBC}, 0);
        check("s5.err_count", 32'(n_err - e0), 32'd1);
        check("s5.unlocked", 32'(lock_o), 32'd0);
        send_sym(K_COMMA, 0);
        check("s5.one_comma", 32'(lock_o), 32'd0);
        send_sym(K_COMMA, 0);
        check("s5.relock", 32'(lock_o), 32'd1);

        // Random frames with random gaps and occasional extra headers.
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 1) == 1) send_sym(K_COMMA, 1'($urandom));
            for (int b = 0; b < NUM_BYTES; b++) begin
                rb = 8'($urandom);
                send_sym({1'b0, rb}, 1'($urandom));
            end
        end

        // 6: scenario 2 with bit_vld_i toggling every cycle.
        v0 = n_valid;
        scenario2(1);
        check("s6.valid_count", 32'(n_valid - v0), 32'd1);
        check("s6.data", data_o, 32'h00A1B2C3);

        // Asynchronous reset mid-byte, between clock edges.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        rst_i = 1'b1;
        bit_vld_i = 1'b0;
        model_reset();
        #1;
        check("s6.async_lock", 32'(lock_o), 32'd0);
        check("s6.async_data", data_o, 32'd0);
        check("s6.async_valid", 32'(valid_o), 32'd0);
        check("s6.async_err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        send_sym(K_COMMA, 1);
        send_sym(K_COMMA, 1);
        check("s6.relock", 32'(lock_o), 32'd1);
        v0 = n_valid;
        scenario2(1);
        check("s6.valid_count2", 32'(n_valid - v0), 32'd1);
        check("s6.data2", data_o, 32'h00A1B2C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
